// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and the sign helper for the RV64M multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;
    localparam int         MD_W      = 3;

    // Widest value the sign helper handles: the 2*XLEN product for XLEN=64.
    localparam int MD_ACC_W = 128;

    typedef enum logic [1:0] {IDLE, CALC, DONE} md_state_e;

    function automatic logic [MD_ACC_W-1:0] neg_if(input logic sign,
                                                   input logic [MD_ACC_W-1:0] val);
        return sign ? (~val + 1'b1) : val;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multi-cycle datapath: MSB-first shift-add for multiply,
// restoring shift-subtract for divide ({remainder, quotient} share the accumulator).
module muldiv_step #(
    parameter int XLEN = 64
) (
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   mpl_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [2*XLEN-1:0] acc_o,
    output logic [XLEN-1:0]   mpl_o
);

    logic [XLEN:0] top;
    logic [XLEN:0] diff;

    always_comb begin
        top   = acc_i[2*XLEN-1:XLEN-1];
        diff  = top - {1'b0, b_i};
        mpl_o = {mpl_i[XLEN-2:0], 1'b0};
        acc_o = {acc_i[2*XLEN-2:0], 1'b0} + (mpl_i[XLEN-1] ? {{XLEN{1'b0}}, b_i} : '0);
        if (is_div_i) begin
            // Shifted partial remainder is below 2*divisor, so diff[XLEN] is a true sign.
            if (!diff[XLEN]) acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
            else             acc_o = {top[XLEN-1:0],  acc_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV64M multiply/divide unit beside the EX ALU; stalls the pipe while
// computing and pulses a one-cycle register write when the result is ready.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            hold_flag_o,
    output logic            busy_o,
    output logic [XLEN-1:0] rd_wdata_o,
    output logic [4:0]      rd_waddr_o,
    output logic            reg_wen_o
);

    localparam int HALF  = XLEN / 2;
    localparam int CNT_W = $clog2(XLEN / UNROLL) + 1;
    localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(XLEN / UNROLL - 1);
    localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(HALF / UNROLL - 1);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [3:0]        op_q;
    logic [4:0]        rd_q;
    logic              quot_neg_q, rem_neg_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   mpl_q, b_q, result_q;

    logic              accept, calc_last, s1, s2, is_w, is_div, a_neg, b_neg, special;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, min_val, special_res, raw, final_res;
    logic [MD_ACC_W-1:0] a_t, b_t, prod_t, q_t, r_t;
    logic [2*XLEN-1:0] acc_ch [0:UNROLL];
    logic [XLEN-1:0]   mpl_ch [0:UNROLL];

    assign accept    = (state_q == IDLE) && start_i && !flush_i;
    assign calc_last = (cnt_q == (op_q[MD_W] ? LAST_HALF : LAST_FULL));

    // Issue decode: extension, magnitudes and the divide corner cases.
    always_comb begin
        is_w   = op_i[MD_W];
        is_div = op_i[2];
        s1     = op_i[2:0] inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
        s2     = op_i[2:0] inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
        a_ext  = is_w ? {{HALF{s1 & op1_i[HALF-1]}}, op1_i[HALF-1:0]} : op1_i;
        b_ext  = is_w ? {{HALF{s2 & op2_i[HALF-1]}}, op2_i[HALF-1:0]} : op2_i;
        a_neg  = s1 & a_ext[XLEN-1];
        b_neg  = s2 & b_ext[XLEN-1];
        a_t    = neg_if(a_neg, MD_ACC_W'(a_ext));
        b_t    = neg_if(b_neg, MD_ACC_W'(b_ext));
        a_mag  = a_t[XLEN-1:0];
        b_mag  = b_t[XLEN-1:0];
        min_val = is_w ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        special     = 1'b0;
        special_res = '0;
        if (is_div && (b_ext == '0)) begin
            special     = 1'b1;
            special_res = op_i[1] ? (is_w ? {{HALF{op1_i[HALF-1]}}, op1_i[HALF-1:0]} : op1_i)
                                  : {XLEN{1'b1}};
        end else if (is_div && s1 && (a_ext == min_val) && (b_ext == {XLEN{1'b1}})) begin
            special     = 1'b1;
            special_res = op_i[1] ? '0 : min_val;
        end
    end

    assign acc_ch[0] = acc_q;
    assign mpl_ch[0] = mpl_q;

    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        muldiv_step #(.XLEN(XLEN)) u_step (
            .is_div_i (op_q[2]),
            .acc_i    (acc_ch[g]),
            .mpl_i    (mpl_ch[g]),
            .b_i      (b_q),
            .acc_o    (acc_ch[g+1]),
            .mpl_o    (mpl_ch[g+1])
        );
    end

    // Sign fix-up and result selection from the accumulator after the last step.
    always_comb begin
        prod_t = neg_if(quot_neg_q, MD_ACC_W'(acc_ch[UNROLL]));
        q_t    = neg_if(quot_neg_q, MD_ACC_W'(acc_ch[UNROLL][XLEN-1:0]));
        r_t    = neg_if(rem_neg_q,  MD_ACC_W'(acc_ch[UNROLL][2*XLEN-1:XLEN]));
        if (op_q[2])                  raw = op_q[1] ? r_t[XLEN-1:0] : q_t[XLEN-1:0];
        else if (op_q[2:0] == MD_MUL) raw = prod_t[XLEN-1:0];
        else                          raw = prod_t[2*XLEN-1:XLEN];
        final_res = op_q[MD_W] ? {{HALF{raw[HALF-1]}}, raw[HALF-1:0]} : raw;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = special ? DONE : CALC;
            CALC: if (flush_i) state_d = IDLE;
                  else if (calc_last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            acc_q      <= '0;
            mpl_q      <= '0;
            b_q        <= '0;
            result_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q       <= op_i;
                rd_q       <= rd_addr_i;
                cnt_q      <= '0;
                quot_neg_q <= a_neg ^ b_neg;
                rem_neg_q  <= a_neg;
                b_q        <= b_mag;
                result_q   <= special_res;
                // W operands go to the top half so MSB-first stepping needs only HALF steps.
                if (is_div) begin
                    acc_q <= {{XLEN{1'b0}}, (is_w ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag)};
                    mpl_q <= '0;
                end else begin
                    acc_q <= '0;
                    mpl_q <= is_w ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
                end
            end else if (state_q == CALC && !flush_i) begin
                acc_q <= acc_ch[UNROLL];
                mpl_q <= mpl_ch[UNROLL];
                cnt_q <= cnt_q + 1'b1;
                if (calc_last) result_q <= final_res;
            end
        end
    end

    assign hold_flag_o = accept || (state_q == CALC);
    assign busy_o      = (state_q != IDLE);
    assign reg_wen_o   = (state_q == DONE);
    assign rd_wdata_o  = (state_q == DONE) ? result_q : '0;
    assign rd_waddr_o  = (state_q == DONE) ? rd_q : '0;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: one UNROLL=1 and one UNROLL=4 instance share the inputs.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [3:0]  op;
    logic [63:0] a, b;
    logic [4:0]  rd;

    logic        hold1, busy1, wen1, hold4, busy4, wen4;
    logic [63:0] wdata1, wdata4;
    logic [4:0]  waddr1, waddr4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(64), .UNROLL(1)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start), .op_i(op), .op1_i(a), .op2_i(b),
        .rd_addr_i(rd), .flush_i(flush), .hold_flag_o(hold1), .busy_o(busy1),
        .rd_wdata_o(wdata1), .rd_waddr_o(waddr1), .reg_wen_o(wen1));

    ex_muldiv #(.XLEN(64), .UNROLL(4)) u_dut4 (
        .clk(clk), .rst(rst), .start_i(start), .op_i(op), .op1_i(a), .op2_i(b),
        .rd_addr_i(rd), .flush_i(flush), .hold_flag_o(hold4), .busy_o(busy4),
        .rd_wdata_o(wdata4), .rd_waddr_o(waddr4), .reg_wen_o(wen4));

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          n;
        string       name;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                          input logic [4:0] r, input logic [63:0] exp, input int n,
                          input string name, input int pokes);
        int lat1, lat4, got1, got4, pulse1, pulse4, hbad1, hbad4, quiet;
        lat1 = (n == 0) ? 1 : n + 1;
        lat4 = (n == 0) ? 1 : n / 4 + 1;
        got1 = 0; got4 = 0; pulse1 = 0; pulse4 = 0; hbad1 = 0; hbad4 = 0; quiet = 0;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; rd = r;
        #1;
        check({name, " hold1@T"}, 64'(hold1), 64'd1);
        check({name, " hold4@T"}, 64'(hold4), 64'd1);
        @(posedge clk);
        for (int k = 1; k <= lat1 + 2; k++) begin
            if (k > 1) @(posedge clk);
            #1;
            if (k > pokes) start = 1'b0;
            else begin op = 4'h5; b = '0; end
            #1;
            if (wen1) begin
                pulse1++;
                if (got1 == 0) begin
                    got1 = k;
                    check({name, " data1"}, wdata1, exp);
                    check({name, " waddr1"}, 64'(waddr1), 64'(r));
                end
            end else if (wdata1 !== '0 || waddr1 !== '0) quiet++;
            if (wen4) begin
                pulse4++;
                if (got4 == 0) begin
                    got4 = k;
                    check({name, " data4"}, wdata4, exp);
                    check({name, " waddr4"}, 64'(waddr4), 64'(r));
                end
            end else if (wdata4 !== '0 || waddr4 !== '0) quiet++;
            if (hold1 !== (k < lat1)) hbad1++;
            if (hold4 !== (k < lat4)) hbad4++;
        end
        check({name, " latency1"}, 64'(got1), 64'(lat1));
        check({name, " latency4"}, 64'(got4), 64'(lat4));
        check({name, " pulses"}, 64'(pulse1 * 16 + pulse4), 64'd17);
        check({name, " hold seq"}, 64'(hbad1 + hbad4), 64'd0);
        check({name, " idle outputs"}, 64'(quiet), 64'd0);
    endtask

    initial begin
        int n_wen;
        vecs[0]  = '{4'h0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 64, "mul 7*-3"};
        vecs[1]  = '{4'h3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64, "mulhu max*max"};
        vecs[2]  = '{4'h2, '1, 64'd2, '1, 64, "mulhsu -1*2"};
        vecs[3]  = '{4'h1, 64'h8000_0000_0000_0000, 64'd2, '1, 64, "mulh min*2"};
        vecs[4]  = '{4'h1, 64'h4000_0000_0000_0000, 64'd4, 64'd1, 64, "mulh 2^62*4"};
        vecs[5]  = '{4'h5, 64'd5, 64'd0, '1, 0, "divu 5/0"};
        vecs[6]  = '{4'h7, 64'd5, 64'd0, 64'd5, 0, "remu 5/0"};
        vecs[7]  = '{4'h4, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0, "div min/-1"};
        vecs[8]  = '{4'h6, 64'h8000_0000_0000_0000, '1, 64'd0, 0, "rem min/-1"};
        vecs[9]  = '{4'hC, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 32, "divw -20/6"};
        vecs[10] = '{4'hE, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 32, "remw -20/6"};
        vecs[11] = '{4'h4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64, "div -7/2"};
        vecs[12] = '{4'h6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 64, "rem -7/2"};
        vecs[13] = '{4'h5, 64'd100, 64'd7, 64'd14, 64, "divu 100/7"};
        vecs[14] = '{4'h7, 64'd100, 64'd7, 64'd2, 64, "remu 100/7"};
        vecs[15] = '{4'h8, 64'h1_0000_0003, 64'd5, 64'd15, 32, "mulw 3*5"};
        vecs[16] = '{4'h8, 64'h1_0000, 64'h8000, 64'hFFFF_FFFF_8000_0000, 32, "mulw 2^31"};
        vecs[17] = '{4'hD, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h7FFF_FFFF, 32, "divuw big/2"};
        vecs[18] = '{4'hF, 64'd7, 64'd0, 64'd7, 0, "remuw 7/0"};
        vecs[19] = '{4'hC, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0, "divw min/-1"};
        vecs[20] = '{4'hE, 64'hFFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 0, "remw -5/0"};
        vecs[21] = '{4'hD, 64'd9, 64'd0, '1, 0, "divuw 9/0"};

        rst = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; rd = '0;
        #2;
        check("reset outputs dut1", {hold1, busy1, wen1, waddr1, wdata1}, '0);
        check("reset outputs dut4", {hold4, busy4, wen4, waddr4, wdata4}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i), vecs[i].exp, vecs[i].n,
                   vecs[i].name, (i == 13) ? 3 : 0);

        // Flush a DIV while it is calculating: back to IDLE, never a write.
        @(negedge clk);
        start = 1'b1; op = 4'h4; a = 64'd100; b = 64'd7; rd = 5'd3;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        check("flush busy1", 64'(busy1), 64'd0);
        check("flush busy4", 64'(busy4), 64'd0);
        check("flush hold1", 64'(hold1), 64'd0);
        n_wen = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (wen1 || wen4) n_wen++;
        end
        check("flush no write", 64'(n_wen), 64'd0);

        // Start and flush together: no accept.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 4'h0; a = 64'd3; b = 64'd3; rd = 5'd4;
        #1;
        check("start+flush hold1", 64'(hold1), 64'd0);
        check("start+flush hold4", 64'(hold4), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("start+flush busy", 64'({busy1, busy4}), 64'd0);

        // Asynchronous reset in the middle of a MUL.
        @(negedge clk);
        start = 1'b1; op = 4'h0; a = 64'd7; b = 64'hFFFF_FFFF_FFFF_FFFD; rd = 5'd9;
        @(posedge clk); #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        check("pre-reset busy1", 64'(busy1), 64'd1);
        rst = 1'b0;
        #1;
        check("mid-op reset dut1", {hold1, busy1, wen1, waddr1, wdata1}, '0);
        check("mid-op reset dut4", {hold4, busy4, wen4, waddr4, wdata4}, '0);
        @(negedge clk) rst = 1'b1;
        run_op(4'h0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd9, 64'hFFFF_FFFF_FFFF_FFEB, 64,
               "mul after reset", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end want end");
        $fatal(1);
    end

endmodule
